lcd_bus_monitor: RTL
====================

// Module: lcd_bus_monitor
// PURPOSE
//  Receive-side model of the HD44780-style 8-bit character LCD bus (LCD_E/RS/RW/DATA).
//  Decodes every write cycle into display-control state and a 2x16 character buffer.
//  The buffer can be read back, so the clock/VFD writers can be self-checked in simulation
//  and the text mirrored to a second display on-chip. Purely a bus listener; it never drives LCD_DATA.
// PARAMETERS
//  CMD_CYC   4   BUSY cycles after any command or data write (excluding clear/home)
//  CLR_CYC   64  BUSY cycles after clear display or return home
// PORTS
//  CLK        in   1  system clock; all logic on posedge CLK
//  RESETN     in   1  reset, synchronous, active-low
//  LCD_E      in   1  bus enable; write is committed on its falling edge
//  LCD_RS     in   1  0 = instruction, 1 = data
//  LCD_RW     in   1  0 = write, 1 = read (reads ignored)
//  LCD_DATA   in   8  bus data
//  RD_ADDR    in   5  buffer read index: 0-15 line 1, 16-31 line 2
//  RD_CHAR    out  8  buffer[RD_ADDR], registered, 1-cycle latency
//  AC         out  7  DDRAM address counter
//  DISP_ON, CUR_ON, BLINK_ON   out 1 each   display-control bits D, C, B
//  INC_MODE, SHIFT_MODE        out 1 each   entry-mode bits I/D, S
//  DL, NL, FONT                out 1 each   function-set bits
//  BUSY       out  1  1 while a committed write is being "executed"
//  INIT_DONE  out  1  sticky; set by the first function set with DL=1
//  OVR_ERR    out  1  sticky; a write arrived while BUSY=1
//  ADDR_ERR   out  1  sticky; set-DDRAM-address with an unmapped address
// BEHAVIOUR
//  Reset (RESETN=0 at posedge):
//   - All outputs 0, except AC=0x00, INC_MODE=1, RD_CHAR=0x20.
//   - All 32 buffer cells = 0x20. FSM = IDLE.
//   - Reset overrides any concurrent bus event.
//  Input sampling:
//   - LCD_E/RS/RW/DATA pass through a 2-FF synchronizer.
//   - Fall = sync E 1->0. On a fall, commit RS/RW/DATA as sampled in the previous cycle (E still high).
//   - RW=1 commits are discarded: no state change, no BUSY.
//  FSM states:
//   - IDLE: on an RW=0 fall, go to EXEC.
//   - EXEC: one cycle; decode and apply the commit. Load the busy counter with CLR_CYC (clear/home) or CMD_CYC (all else). Go to BUSY.
//   - BUSY: decrement the counter; go to IDLE in the cycle it reaches 0. BUSY output is 1 in EXEC and BUSY states.
//   - A fall arriving in EXEC or BUSY is dropped and sets OVR_ERR.
//  Instruction decode (RS=0), highest set bit wins:
//   - b7 set DDRAM address: AC = DATA[6:0] if in 0x00-0x27 or 0x40-0x67; otherwise AC = 0x00 and ADDR_ERR is set.
//   - b6 set CGRAM address: accepted, no effect except BUSY.
//   - b5 function set: DL=b4, NL=b3, FONT=b2. If b4=1, set INIT_DONE.
//   - b4 shift: if b3=0, cursor move (AC +1 when b2=1, -1 when b2=0, with wrap); if b3=1, display shift, no effect.
//   - b3 display control: DISP_ON=b2, CUR_ON=b1, BLINK_ON=b0.
//   - b2 entry mode: INC_MODE=b1, SHIFT_MODE=b0.
//   - b1 return home: AC = 0x00; buffer unchanged.
//   - b0 clear: all 32 cells = 0x20 in the EXEC cycle; AC = 0x00; INC_MODE = 1.
//   - 0x00: no-op, CMD_CYC busy.
//  Data write (RS=1):
//   - If AC is in 0x00-0x0F, write cell AC. If AC is in 0x40-0x4F, write cell 16 + AC[3:0].
//   - Any other AC: no cell written (off-screen); AC still steps.
//   - Then AC steps +1 if INC_MODE=1, else -1.
//  AC wrap:
//   - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
//   - Decrement: 0x40 -> 0x27, 0x00 -> 0x67.
//   - AC never holds an unmapped value.
//  Read port:
//   - RD_CHAR <= buffer[RD_ADDR] every cycle, independent of BUSY.
//   - A cell written in EXEC is visible on RD_CHAR two cycles later when RD_ADDR is held.
//  Reset mid-operation: the busy counter and FSM clear immediately; a partially observed E pulse is forgotten.
// TESTING
//  - Reset, then hold RD_ADDR=0..31 -> RD_CHAR=0x20 for every cell; AC=0; BUSY=0; all error flags 0.
//  - Writes 0x3C, 0x0C, 0x06 (RS=0) -> DL=1, NL=1, FONT=1, INIT_DONE=1, DISP_ON=1, INC_MODE=1; BUSY high for CMD_CYC+1 cycles after each fall.
//  - Writes 0x80, then data 0x31 0x32 -> cells 0,1 = '1','2', AC=0x02. Write 0xC0, then 0x39 -> cell 16 = 0x39, AC=0x41.
//  - AC=0x27 with a data write -> no cell written, AC=0x40. Entry 0x04 (decrement) with AC=0x00 and a data write -> cell 0 written, AC=0x67.
//  - Write 0x01 -> all cells 0x20, AC=0; BUSY for CLR_CYC+1 cycles. A second fall at CLR_CYC/2 -> ignored, OVR_ERR=1.
//  - Write 0xA8 (address 0x28) -> AC=0x00, ADDR_ERR=1. RW=1 cycle -> no state change, BUSY stays 0. RESETN low mid-BUSY -> BUSY=0 next cycle.

Source files
------------

// File: rtl/lcd_bus_monitor_if.sv
// rtl/lcd_bus_monitor_if.sv - HD44780-style LCD bus plus buffer read port and decoded state
interface lcd_bus_monitor_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;
   logic [6:0] ac;
   logic       disp_on;
   logic       cur_on;
   logic       blink_on;
   logic       inc_mode;
   logic       shift_mode;
   logic       dl;
   logic       nl;
   logic       font;
   logic       busy;
   logic       init_done;
   logic       ovr_err;
   logic       addr_err;

   modport master (
      output lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
      input  rd_char, ac, disp_on, cur_on, blink_on, inc_mode, shift_mode,
             dl, nl, font, busy, init_done, ovr_err, addr_err
   );

   modport slave (
      input  lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
      output rd_char, ac, disp_on, cur_on, blink_on, inc_mode, shift_mode,
             dl, nl, font, busy, init_done, ovr_err, addr_err
   );
endinterface

// File: rtl/lcd_bus_monitor.sv
// rtl/lcd_bus_monitor.sv - passive HD44780 bus listener with 2x16 character mirror
module lcd_bus_monitor #(
   parameter int CMD_CYC = 4,
   parameter int CLR_CYC = 64
) (
   input logic              clk_i,
   input logic              resetn_i,
   lcd_bus_monitor_if.slave bus
);
   localparam int MAXC = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY} state_t;

   state_t      state_q;
   logic [CW-1:0] cnt_q;
   logic        busy_q;

   logic        e_s1_q, e_s2_q, e_s3_q;
   logic        rs_s1_q, rs_s2_q, rs_s3_q;
   logic        rw_s1_q, rw_s2_q, rw_s3_q;
   logic [7:0]  data_s1_q, data_s2_q, data_s3_q;

   logic        cmd_rs_q;
   logic [7:0]  cmd_data_q;

   logic [7:0]  cells_q [32];
   logic [7:0]  rd_char_q;
   logic [6:0]  ac_q, ac_d;
   logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic        inc_q, inc_d, shift_q, shift_d;
   logic        dl_q, dl_d, nl_q, nl_d, font_q, font_d;
   logic        init_done_q, ovr_err_q, addr_err_q;

   logic        init_set, addr_err_set, wr_en, clr_all;
   logic [4:0]  wr_idx;
   logic [CW-1:0] cnt_load;
   logic        fall_wr;

   // Stage 3 holds the values seen in the last cycle E was still high.
   assign fall_wr = e_s3_q & ~e_s2_q & ~rw_s3_q;

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == 7'h27)      return 7'h40;
         else if (a == 7'h67) return 7'h00;
         else                 return a + 7'd1;
      end else begin
         if (a == 7'h40)      return 7'h27;
         else if (a == 7'h00) return 7'h67;
         else                 return a - 7'd1;
      end
   endfunction

   always_comb begin
      ac_d         = ac_q;
      disp_d       = disp_q;
      cur_d        = cur_q;
      blink_d      = blink_q;
      inc_d        = inc_q;
      shift_d      = shift_q;
      dl_d         = dl_q;
      nl_d         = nl_q;
      font_d       = font_q;
      init_set     = 1'b0;
      addr_err_set = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = {ac_q[6], ac_q[3:0]};
      clr_all      = 1'b0;
      cnt_load     = CW'(CMD_CYC);
      if (cmd_rs_q) begin
         wr_en = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
         ac_d  = ac_step(ac_q, inc_q);
      end else if (cmd_data_q[7]) begin
         if ((cmd_data_q[6:0] <= 7'h27) ||
             (cmd_data_q[6:0] >= 7'h40 && cmd_data_q[6:0] <= 7'h67)) begin
            ac_d = cmd_data_q[6:0];
         end else begin
            ac_d         = 7'h00;
            addr_err_set = 1'b1;
         end
      end else if (cmd_data_q[6]) begin
         ac_d = ac_q;
      end else if (cmd_data_q[5]) begin
         dl_d     = cmd_data_q[4];
         nl_d     = cmd_data_q[3];
         font_d   = cmd_data_q[2];
         init_set = cmd_data_q[4];
      end else if (cmd_data_q[4]) begin
         if (!cmd_data_q[3]) ac_d = ac_step(ac_q, cmd_data_q[2]);
      end else if (cmd_data_q[3]) begin
         disp_d  = cmd_data_q[2];
         cur_d   = cmd_data_q[1];
         blink_d = cmd_data_q[0];
      end else if (cmd_data_q[2]) begin
         inc_d   = cmd_data_q[1];
         shift_d = cmd_data_q[0];
      end else if (cmd_data_q[1]) begin
         ac_d     = 7'h00;
         cnt_load = CW'(CLR_CYC);
      end else if (cmd_data_q[0]) begin
         ac_d     = 7'h00;
         inc_d    = 1'b1;
         clr_all  = 1'b1;
         cnt_load = CW'(CLR_CYC);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         e_s1_q      <= 1'b0; e_s2_q  <= 1'b0; e_s3_q  <= 1'b0;
         rs_s1_q     <= 1'b0; rs_s2_q <= 1'b0; rs_s3_q <= 1'b0;
         rw_s1_q     <= 1'b0; rw_s2_q <= 1'b0; rw_s3_q <= 1'b0;
         data_s1_q   <= 8'h00; data_s2_q <= 8'h00; data_s3_q <= 8'h00;
         cmd_rs_q    <= 1'b0;
         cmd_data_q  <= 8'h00;
         for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
         rd_char_q   <= 8'h20;
         ac_q        <= 7'h00;
         disp_q      <= 1'b0; cur_q <= 1'b0; blink_q <= 1'b0;
         inc_q       <= 1'b1; shift_q <= 1'b0;
         dl_q        <= 1'b0; nl_q <= 1'b0; font_q <= 1'b0;
         init_done_q <= 1'b0;
         ovr_err_q   <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         e_s1_q    <= bus.lcd_e;    e_s2_q    <= e_s1_q;    e_s3_q    <= e_s2_q;
         rs_s1_q   <= bus.lcd_rs;   rs_s2_q   <= rs_s1_q;   rs_s3_q   <= rs_s2_q;
         rw_s1_q   <= bus.lcd_rw;   rw_s2_q   <= rw_s1_q;   rw_s3_q   <= rw_s2_q;
         data_s1_q <= bus.lcd_data; data_s2_q <= data_s1_q; data_s3_q <= data_s2_q;
         rd_char_q <= cells_q[bus.rd_addr];
         case (state_q)
            S_IDLE: begin
               if (fall_wr) begin
                  cmd_rs_q   <= rs_s3_q;
                  cmd_data_q <= data_s3_q;
                  state_q    <= S_EXEC;
                  busy_q     <= 1'b1;
               end
            end
            S_EXEC: begin
               ac_q    <= ac_d;
               disp_q  <= disp_d;  cur_q   <= cur_d;  blink_q <= blink_d;
               inc_q   <= inc_d;   shift_q <= shift_d;
               dl_q    <= dl_d;    nl_q    <= nl_d;   font_q  <= font_d;
               if (init_set)     init_done_q <= 1'b1;
               if (addr_err_set) addr_err_q  <= 1'b1;
               if (clr_all) begin
                  for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
               end else if (wr_en) begin
                  cells_q[wr_idx] <= cmd_data_q;
               end
               if (fall_wr) ovr_err_q <= 1'b1;
               cnt_q   <= cnt_load;
               state_q <= S_BUSY;
            end
            S_BUSY: begin
               if (fall_wr) ovr_err_q <= 1'b1;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q <= CW'(1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_char    = rd_char_q;
   assign bus.ac         = ac_q;
   assign bus.disp_on    = disp_q;
   assign bus.cur_on     = cur_q;
   assign bus.blink_on   = blink_q;
   assign bus.inc_mode   = inc_q;
   assign bus.shift_mode = shift_q;
   assign bus.dl         = dl_q;
   assign bus.nl         = nl_q;
   assign bus.font       = font_q;
   assign bus.busy       = busy_q;
   assign bus.init_done  = init_done_q;
   assign bus.ovr_err    = ovr_err_q;
   assign bus.addr_err   = addr_err_q;
endmodule
